// File: rtl/vedic_mul_iter_if.sv
// Operand/product handshake bundle for vedic_mul_iter.
// With VEDIC_MUL_SIGNED_EN defined the bundle also carries the sgn select.
interface vedic_mul_iter_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 abort;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
`ifdef VEDIC_MUL_SIGNED_EN
    logic                 sgn;

    modport master (
        output in_valid, a, b, abort, out_ready, sgn,
        input  in_ready, out_valid, product
    );
    modport slave (
        input  in_valid, a, b, abort, out_ready, sgn,
        output in_ready, out_valid, product
    );
`else
    modport master (
        output in_valid, a, b, abort, out_ready,
        input  in_ready, out_valid, product
    );
    modport slave (
        input  in_valid, a, b, abort, out_ready,
        output in_ready, out_valid, product
    );
`endif
endinterface

// File: rtl/vedic_mul_iter.sv
// Iterative multiplier: one 4x4 vedic digit product per cycle, D*D cycles per operation.
// Optional signed mode enabled by defining VEDIC_MUL_SIGNED_EN (adds bus.sgn).
module vedic_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    vedic_mul_iter_if.slave  bus
);
    localparam int D  = WIDTH / 4;
    localparam int PW = 2 * WIDTH;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic c1;
        c1 = x[1] & y[0] & x[0] & y[1];
        return {x[1] & y[1] & c1, (x[1] & y[1]) ^ c1, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
    endfunction

    // Vertical-and-crosswise split into four 2x2 products
    function automatic logic [7:0] vedic4x4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = vedic2x2(x[1:0], y[1:0]);
        q1 = vedic2x2(x[3:2], y[1:0]);
        q2 = vedic2x2(x[1:0], y[3:2]);
        q3 = vedic2x2(x[3:2], y[3:2]);
        return {4'b0000, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'b0000};
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] x);
        return ~x + PW'(1);
    endfunction

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d, prod_q, prod_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d;
    logic            neg_q, neg_d;
    logic            in_ready_s, out_valid_s, last_s, sgn_s;
    logic [7:0]      pp_s;
    logic [IW:0]     ij_s;
    logic [PW-1:0]   sum_s;

`ifdef VEDIC_MUL_SIGNED_EN
    assign sgn_s = bus.sgn;
`else
    assign sgn_s = 1'b0;
`endif

    assign pp_s   = vedic4x4(a_q[{i_q, 2'b00} +: 4], b_q[{j_q, 2'b00} +: 4]);
    assign ij_s   = {1'b0, i_q} + {1'b0, j_q};
    assign sum_s  = acc_q + ({{(PW-8){1'b0}}, pp_s} << {ij_s, 2'b00});
    assign last_s = (i_q == LAST_IDX) && (j_q == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over every other request
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = bus.in_valid ? BUSY : IDLE;
                BUSY:    state_d = last_s ? DONE : BUSY;
                DONE:    state_d = bus.out_ready ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            IDLE:    in_ready_s  = 1'b1;
            DONE:    out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath next-state: operand capture, digit walk, accumulate, result latch
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        i_d    = i_q;
        j_d    = j_q;
        neg_d  = neg_q;
        prod_d = prod_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.abort) begin
                    // Signed operands are reduced to magnitudes; the sign is reapplied at the end
                    a_d   = (sgn_s && bus.a[WIDTH-1]) ? neg_w(bus.a) : bus.a;
                    b_d   = (sgn_s && bus.b[WIDTH-1]) ? neg_w(bus.b) : bus.b;
                    neg_d = sgn_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d = '0;
                    i_d   = '0;
                    j_d   = '0;
                end else begin
                    acc_d = acc_q;
                end
            end
            BUSY: begin
                if (bus.abort) begin
                    acc_d = '0;
                    i_d   = '0;
                    j_d   = '0;
                end else begin
                    acc_d = sum_s;
                    if (last_s) begin
                        i_d    = '0;
                        j_d    = '0;
                        prod_d = neg_q ? neg_p(sum_s) : sum_s;
                    end else if (j_q == LAST_IDX) begin
                        j_d = '0;
                        i_d = i_q + IW'(1);
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            i_q    <= '0;
            j_q    <= '0;
            neg_q  <= 1'b0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            i_q    <= i_d;
            j_q    <= j_d;
            neg_q  <= neg_d;
            prod_q <= prod_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.product   = prod_q;

endmodule

// File: tb/tb_vedic_mul_iter.sv
// Scoreboard bench for vedic_mul_iter (WIDTH=8): directed vectors, queued expectations, monitor checks.
module tb_vedic_mul_iter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vedic_mul_iter_if #(.WIDTH(8)) bus();

    vedic_mul_iter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] exp_q[$];
    logic [15:0] last_prod = 16'h0000;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every accepted product is compared against the oldest expectation
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("product", {16'h0000, bus.product}, {16'h0000, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic handshake(input logic [7:0] a, input logic [7:0] b, input logic s);
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
`ifdef VEDIC_MUL_SIGNED_EN
        bus.sgn = s;
`else
        if (s) $display("note: sgn ignored without signed build");
`endif
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = 8'h5A;
        bus.b = 8'hC3;
    endtask

    // One full operation; stall holds out_ready low for that many DONE cycles
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] expv, input int stall);
        int cyc;
        bus.out_ready = (stall == 0);
        exp_q.push_back(expv);
        handshake(a, b, s);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            chk("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("busy_product_hold", {16'h0000, bus.product}, {16'h0000, last_prod});
            @(posedge clk); #1;
            cyc++;
        end
        // Handshake cycle plus D*D = 4 busy cycles
        chk("latency", cyc, 32'd4);
        chk("done_in_ready", {31'd0, bus.in_ready}, 32'd0);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_product", {16'h0000, bus.product}, {16'h0000, expv});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("back_to_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        chk("idle_product_hold", {16'h0000, bus.product}, {16'h0000, expv});
        last_prod = expv;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = 8'h00;
        bus.b = 8'h00;
`ifdef VEDIC_MUL_SIGNED_EN
        bus.sgn = 1'b0;
`endif
        #12;
        chk("reset_state", {14'd0, bus.in_ready, bus.out_valid, bus.product}, {14'd0, 2'b10, 16'h0000});
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
        do_op(8'h00, 8'hA5, 1'b0, 16'h0000, 0);
        do_op(8'h01, 8'hA5, 1'b0, 16'h00A5, 0);
        do_op(8'h12, 8'h34, 1'b0, 16'h03A8, 10);

        // Abort on the second busy cycle
        bus.out_ready = 1'b1;
        handshake(8'h77, 8'h33, 1'b0);
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_busy_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        chk("abort_product_hold", {16'h0000, bus.product}, {16'h0000, last_prod});
        do_op(8'h0F, 8'h0F, 1'b0, 16'h00E1, 0);

        // Abort with in_valid in IDLE must not accept operands
        bus.in_valid = 1'b1;
        bus.abort = 1'b1;
        bus.a = 8'h22;
        bus.b = 8'h22;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.abort = 1'b0;
        chk("abort_idle_reject", {31'd0, bus.in_ready}, 32'd1);

        // Abort while waiting in DONE
        bus.out_ready = 1'b0;
        handshake(8'h03, 8'h03, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("done_reached", {31'd0, bus.out_valid}, 32'd1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
        chk("abort_done_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        last_prod = 16'h0009;

        // Reset dropped off-edge mid-busy
        handshake(8'h99, 8'h99, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {14'd0, bus.in_ready, bus.out_valid, bus.product}, {14'd0, 2'b10, 16'h0000});
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_prod = 16'h0000;
        repeat (8) begin
            @(posedge clk); #1;
            chk("reset_no_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        do_op(8'hFF, 8'h01, 1'b0, 16'h00FF, 0);

`ifdef VEDIC_MUL_SIGNED_EN
        do_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, 0);
        do_op(8'hFD, 8'h05, 1'b0, 16'h04F1, 0);
`endif

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
